// File: rtl/multicycle_sequencer.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM/WB sequencer for the 16-bit datapath.
// Drives PC/IR/RF strobes and the shared memory port with a wait-state timeout.
module multicycle_sequencer #(
    parameter int OPW         = 4,
    parameter int MEM_TIMEOUT = 15,
    parameter int CNTW        = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [OPW-1:0]  opcode,
    input  logic            halt_dec,
    input  logic [1:0]      branch_dec,
    input  logic            memw_dec,
    input  logic            memr_dec,
    input  logic            regw_dec,
    input  logic            branch_taken,
    input  logic            mem_ready,
    output logic            mem_req,
    output logic            mem_we,
    output logic            mem_addr_sel,
    output logic            ir_we,
    output logic            pc_we,
    output logic [1:0]      pc_sel,
    output logic            rf_we,
    output logic            busy,
    output logic            halted,
    output logic            error,
    output logic [2:0]      state,
    output logic [CNTW-1:0] instr_count
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        FETCH  = 3'd1,
        DECODE = 3'd2,
        EXEC   = 3'd3,
        MEM    = 3'd4,
        WB     = 3'd5,
        HALT   = 3'd6,
        ERR    = 3'd7
    } state_t;

    localparam logic [7:0] LIMIT = 8'(MEM_TIMEOUT - 1);

    state_t          cur;
    state_t          nxt;
    logic [7:0]      wait_cnt;
    logic [CNTW-1:0] count;
    logic            retire;
    logic            timeout;
    logic            entering;
    logic            waiting;

    // opcode is carried for trace only; nothing decodes it here
    logic unused;
    assign unused = ^opcode;

    assign timeout  = (wait_cnt == LIMIT);
    assign entering = (nxt != cur) && (nxt == FETCH || nxt == MEM);
    assign waiting  = (cur == FETCH || cur == MEM) && !mem_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cur      <= IDLE;
            wait_cnt <= '0;
            count    <= '0;
        end else begin
            cur <= nxt;
            if (entering)
                wait_cnt <= '0;
            else if (waiting)
                wait_cnt <= wait_cnt + 8'd1;
            if (retire)
                count <= count + CNTW'(1);
        end
    end

    always_comb begin
        nxt          = cur;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = 1'b0;
        ir_we        = 1'b0;
        pc_we        = 1'b0;
        pc_sel       = 2'b00;
        rf_we        = 1'b0;
        retire       = 1'b0;
        unique case (cur)
            IDLE: begin
                if (start)
                    nxt = FETCH;
            end
            FETCH: begin
                mem_req = 1'b1;
                if (mem_ready) begin
                    ir_we = 1'b1;
                    pc_we = 1'b1;
                    nxt   = DECODE;
                end else if (timeout) begin
                    nxt = ERR;
                end
            end
            DECODE: begin
                if (halt_dec)
                    nxt = HALT;
                else if (branch_dec == 2'b11)
                    nxt = ERR;
                else if (memw_dec && memr_dec)
                    nxt = ERR;
                else
                    nxt = EXEC;
            end
            EXEC: begin
                // branches override any memory or writeback fields
                if (branch_dec == 2'b01) begin
                    pc_we  = branch_taken;
                    pc_sel = branch_taken ? 2'b01 : 2'b00;
                    nxt    = FETCH;
                    retire = 1'b1;
                end else if (branch_dec == 2'b10) begin
                    pc_we  = 1'b1;
                    pc_sel = 2'b10;
                    nxt    = FETCH;
                    retire = 1'b1;
                end else if (memw_dec || memr_dec) begin
                    nxt = MEM;
                end else if (regw_dec) begin
                    nxt = WB;
                end else begin
                    nxt    = FETCH;
                    retire = 1'b1;
                end
            end
            MEM: begin
                mem_req      = 1'b1;
                mem_addr_sel = 1'b1;
                mem_we       = memw_dec;
                if (mem_ready) begin
                    if (memr_dec) begin
                        nxt = WB;
                    end else begin
                        nxt    = FETCH;
                        retire = 1'b1;
                    end
                end else if (timeout) begin
                    nxt = ERR;
                end
            end
            WB: begin
                rf_we  = 1'b1;
                nxt    = FETCH;
                retire = 1'b1;
            end
            HALT: nxt = HALT;
            ERR:  nxt = ERR;
        endcase
    end

    assign busy        = (cur != IDLE) && (cur != HALT) && (cur != ERR);
    assign halted      = (cur == HALT);
    assign error       = (cur == ERR);
    assign state       = cur;
    assign instr_count = count;

endmodule
